// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words arrive over valid/ready and leave MSB-first on dout.
// Optional: define SER_PARITY_EN to append an even-parity bit (XOR of the word) after every word.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_word,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hbuf_reg;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [CNT_W-1:0] bitcnt_reg, bitcnt_next;
    logic             hvalid_reg, hvalid_next;
    logic             dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             accept, load;
`ifdef SER_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // The holding buffer only accepts when empty, so accept and load never coincide.
    assign din_ready   = ~hvalid_reg & rst_n;
    assign accept      = din_valid & din_ready;
    assign hvalid_next = load ? 1'b0 : (accept ? 1'b1 : hvalid_reg);
`ifdef SER_PARITY_EN
    assign parity_next = load ? ^hbuf_reg : parity_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hvalid_reg     <= 1'b0;
            hbuf_reg       <= '0;
            sreg_reg       <= '0;
            bitcnt_reg     <= '0;
            dout_reg       <= IDLE_LEVEL;
            dout_valid_reg <= 1'b0;
`ifdef SER_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            hvalid_reg     <= hvalid_next;
            sreg_reg       <= sreg_next;
            bitcnt_reg     <= bitcnt_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            if (accept) begin
                hbuf_reg <= din_word;
            end
`ifdef SER_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        sreg_next   = sreg_reg;
        bitcnt_next = bitcnt_reg;
        load        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hvalid_reg) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bitcnt_reg == LAST_BIT) begin
`ifdef SER_PARITY_EN
                    state_next = PAR;
`else
                    if (hvalid_reg) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end else begin
                    sreg_next   = sreg_reg << 1;
                    bitcnt_next = bitcnt_reg + CNT_W'(1);
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                if (hvalid_reg) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        // A load restarts the frame from the buffered word's MSB with no gap.
        if (load) begin
            sreg_next   = hbuf_reg;
            bitcnt_next = '0;
        end
    end

    always_comb begin
        dout_next       = IDLE_LEVEL;
        dout_valid_next = 1'b0;
        case (state_next)
            SHIFT: begin
                dout_next       = sreg_next[WIDTH-1];
                dout_valid_next = 1'b1;
            end
`ifdef SER_PARITY_EN
            PAR: begin
                dout_next       = parity_reg;
                dout_valid_next = 1'b1;
            end
`endif
            default: begin
                dout_next       = IDLE_LEVEL;
                dout_valid_next = 1'b0;
            end
        endcase
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign busy       = (state_reg != IDLE) | hvalid_reg;

endmodule
